// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by the raster generator and renderers.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_SYNC_DELAY = 2;

    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register (DEPTH = 0 is a wire) that resets every stage to all-ones; keeps idle-high syncs inactive.
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_reset;
            assign o_dat    = i_dat;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '1;
                    end
                end else begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY/blank/line_start/frame_start decode the counters with zero latency; hs/vs lag SYNC_DELAY cycles.
// Free-running, no backpressure. Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic   vga_clk,
    input  logic   reset,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   blank,
    output logic   hs,
    output logic   vs,
    output logic   line_start,
    output logic   frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam coord_t HC_LAST = to_coord(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t VC_LAST = to_coord(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t HV_END  = to_coord(H_VISIBLE);
    localparam coord_t VV_END  = to_coord(V_VISIBLE);
    localparam coord_t HS_LO   = to_coord(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI   = to_coord(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_LO   = to_coord(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI   = to_coord(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t     r_hc;
    coord_t     r_vc;
    logic       w_hc_last;
    logic       w_frame_wrap;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [1:0] w_sync_dly;

    assign w_hc_last    = (r_hc == HC_LAST);
    assign w_frame_wrap = w_hc_last && (r_vc == VC_LAST);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_hc_last) begin
            r_hc <= '0;
            r_vc <= w_frame_wrap ? '0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = (r_hc < HV_END) && (r_vc < VV_END);
    assign line_start  = (r_hc == '0);
    assign frame_start = (r_hc == '0) && (r_vc == '0);

    // Raw syncs are active low; the delay line lines them up with the renderers' ROM + output register.
    assign w_hs_raw = !((r_hc >= HS_LO) && (r_hc < HS_HI));
    assign w_vs_raw = !((r_vc >= VS_LO) && (r_vc < VS_HI));

    sync_delay_line #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (2)
    ) u_sync_dly (
        .i_clk   (vga_clk),
        .i_reset (reset),
        .i_dat   ({w_hs_raw, w_vs_raw}),
        .o_dat   (w_sync_dly)
    );

    assign hs = w_sync_dly[1];
    assign vs = w_sync_dly[0];

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a full-size instance (SYNC_DELAY 2) and a shrunken-timing instance (SYNC_DELAY 0) share one reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct packed {
        obs_t        big;
        obs_t        sml;
        logic [31:0] phase;
        logic [31:0] idx;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  big_x, big_y, sml_x, sml_y;
    logic        big_blank, big_hs, big_vs, big_ls, big_fs;
    logic        sml_blank, sml_hs, sml_vs, sml_ls, sml_fs;
    logic [15:0] big_fc, sml_fc;

    vga_timing_gen u_big (
        .vga_clk     (clk),
        .reset       (reset),
        .DrawX       (big_x),
        .DrawY       (big_y),
        .blank       (big_blank),
        .hs          (big_hs),
        .vs          (big_vs),
        .line_start  (big_ls),
        .frame_start (big_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (big_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .SYNC_DELAY (0)
    ) u_sml (
        .vga_clk     (clk),
        .reset       (reset),
        .DrawX       (sml_x),
        .DrawY       (sml_y),
        .blank       (sml_blank),
        .hs          (sml_hs),
        .vs          (sml_vs),
        .line_start  (sml_ls),
        .frame_start (sml_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (sml_fc)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign big_fc = '0;
    assign sml_fc = '0;
`endif

    // Reference timing for both instances: index 0 = full size, 1 = shrunken.
    int cfg_hv[2] = '{640, 8};
    int cfg_hf[2] = '{16, 2};
    int cfg_hs[2] = '{96, 3};
    int cfg_hb[2] = '{48, 2};
    int cfg_vv[2] = '{480, 4};
    int cfg_vf[2] = '{10, 1};
    int cfg_vs[2] = '{2, 2};
    int cfg_vb[2] = '{33, 1};
    int cfg_d[2]  = '{2, 0};

    int          m_hc[2];
    int          m_vc[2];
    logic [1:0]  m_hist[2][5];
    logic [15:0] m_fc[2];
    int          m_idx;
    int          phase;

    rec_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    int p1_hs_low = 0, p1_blank_l0 = 0, p1_ls = 0;
    int p1_hs_first_x = -1;
    int sm_vs_low = 0, sm_fs = 0, sm_bad_blank = 0;
    int sm_hs_first_x = -1;
    int p2_hs_first_x = -1, p2_hs_first_y = -1;
    logic [15:0] sm_fc_seen[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] model_raw(input int k);
        logic h_lo, v_lo;
        h_lo = (m_hc[k] >= cfg_hv[k] + cfg_hf[k]) && (m_hc[k] < cfg_hv[k] + cfg_hf[k] + cfg_hs[k]);
        v_lo = (m_vc[k] >= cfg_vv[k] + cfg_vf[k]) && (m_vc[k] < cfg_vv[k] + cfg_vf[k] + cfg_vs[k]);
        return {!h_lo, !v_lo};
    endfunction

    task automatic model_edge(input int k, input logic rst);
        int htot, vtot;
        htot = cfg_hv[k] + cfg_hf[k] + cfg_hs[k] + cfg_hb[k];
        vtot = cfg_vv[k] + cfg_vf[k] + cfg_vs[k] + cfg_vb[k];
        if (rst) begin
            m_hc[k] = 0;
            m_vc[k] = 0;
            m_fc[k] = '0;
            for (int i = 0; i < 5; i++) m_hist[k][i] = 2'b11;
        end else begin
            for (int i = 4; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = model_raw(k);
            if (m_hc[k] == htot - 1) begin
                m_hc[k] = 0;
                if (m_vc[k] == vtot - 1) begin
                    m_vc[k] = 0;
                    m_fc[k] = m_fc[k] + 16'd1;
                end else begin
                    m_vc[k] = m_vc[k] + 1;
                end
            end else begin
                m_hc[k] = m_hc[k] + 1;
            end
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t       o;
        logic [1:0] s;
        s       = (cfg_d[k] == 0) ? model_raw(k) : m_hist[k][cfg_d[k]-1];
        o.x     = 10'(m_hc[k]);
        o.y     = 10'(m_vc[k]);
        o.blank = (m_hc[k] < cfg_hv[k]) && (m_vc[k] < cfg_vv[k]);
        o.hs    = s[1];
        o.vs    = s[0];
        o.ls    = (m_hc[k] == 0);
        o.fs    = (m_hc[k] == 0) && (m_vc[k] == 0);
`ifdef VGA_FRAME_CNT_EN
        o.fc    = m_fc[k];
`else
        o.fc    = '0;
`endif
        return o;
    endfunction

    // Applies one clock edge to the model with the reset level the DUT saw and queues the expectation.
    task automatic edge_push();
        rec_t r;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_edge(k, reset);
        m_idx   = reset ? 0 : m_idx + 1;
        r.big   = model_obs(0);
        r.sml   = model_obs(1);
        r.phase = 32'(phase);
        r.idx   = 32'(m_idx);
        q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            obs_t a_big, a_sml;
            r = q.pop_front();
            a_big = '{big_x, big_y, big_blank, big_hs, big_vs, big_ls, big_fs, big_fc};
            a_sml = '{sml_x, sml_y, sml_blank, sml_hs, sml_vs, sml_ls, sml_fs, sml_fc};
            chk($sformatf("sb_big ph%0d idx%0d", r.phase, r.idx), 64'(a_big), 64'(r.big));
            chk($sformatf("sb_sml ph%0d idx%0d", r.phase, r.idx), 64'(a_sml), 64'(r.sml));
            if (r.phase == 1) begin
                if (a_big.y == 0 && !a_big.hs) p1_hs_low++;
                if (!a_big.hs && p1_hs_first_x < 0) p1_hs_first_x = int'(a_big.x);
                if (a_big.y == 0 && a_big.blank) p1_blank_l0++;
                if (r.idx < 1500 && a_big.ls) p1_ls++;
                if (r.idx < 120 && !a_sml.vs) sm_vs_low++;
                if (r.idx < 1200 && a_sml.fs) sm_fs++;
                if (!a_sml.hs && sm_hs_first_x < 0) sm_hs_first_x = int'(a_sml.x);
                if (a_sml.fs && sm_fc_seen.size() < 4) sm_fc_seen.push_back(a_sml.fc);
            end
            if (r.phase == 2 && !a_big.hs && p2_hs_first_x < 0) begin
                p2_hs_first_x = int'(a_big.x);
                p2_hs_first_y = int'(a_big.y);
            end
            if (a_sml.blank && a_sml.y >= 4) sm_bad_blank++;
        end
    end

    initial begin
        int guard;
        m_idx = 0;
        phase = 0;
        reset = 1'b1;
        repeat (2) edge_push();
        phase = 1;
        edge_push();
        reset = 1'b0;

        guard = 0;
        while (!(m_hc[0] == 700 && m_vc[0] == 1) && guard < 5000) begin
            edge_push();
            guard++;
        end
        chk("reach_hc700_line1", 64'(guard < 5000), 64'd1);

        // Reset lands in the middle of the hs pulse and is held for three edges.
        reset = 1'b1;
        phase = 3;
        repeat (2) edge_push();
        phase = 2;
        edge_push();
        reset = 1'b0;
        repeat (1000) edge_push();

        @(negedge clk);
        #1;
        chk("sb_drained", 64'(q.size()), 64'd0);
        chk("line0_hs_low_cycles", 64'(p1_hs_low), 64'd96);
        chk("line0_hs_first_low_x", 64'(p1_hs_first_x), 64'd658);
        chk("line0_blank_cycles", 64'(p1_blank_l0), 64'd640);
        chk("line_start_pulses_1500", 64'(p1_ls), 64'd2);
        chk("sml_vs_low_cycles", 64'(sm_vs_low), 64'd30);
        chk("sml_frame_start_1200", 64'(sm_fs), 64'd10);
        chk("sml_hs_first_low_x_d0", 64'(sm_hs_first_x), 64'd10);
        chk("sml_blank_in_vblank", 64'(sm_bad_blank), 64'd0);
        chk("post_reset_hs_first_x", 64'(p2_hs_first_x), 64'd658);
        chk("post_reset_hs_first_y", 64'(p2_hs_first_y), 64'd0);
`ifdef VGA_FRAME_CNT_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("frame_count_at_fs%0d", i),
                64'((i < sm_fc_seen.size()) ? sm_fc_seen[i] : 16'hdead), 64'(i));
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
